joy_splitter_scheduler: RTL and testbench
=========================================

Name: joy_splitter_scheduler

Overview:
Time-multiplexes the single physical DB9 joystick port between two joysticks wired through a hardware splitter. Drives the splitter select line and waits a settle time after each switch. Samples the port once per slot and presents two stable, registered 6-bit joystick words (FUDLR-style, active-low) to the joystick protocol decoder. When the splitter is disabled, the block passes the port straight through as joystick 1.

Parameters:
SLOT_CYCLES, 140000, clk cycles per joystick slot (28 MHz / 140000 = 200 Hz switch rate, 100 Hz per joystick); must be > SETTLE_CYCLES+1
SETTLE_CYCLES, 64, cycles after a select change before the port is sampled; must be >= 1

Ports:
clk  in  1  system clock (single clock domain)
rst  in  1  asynchronous, active-high reset
split_en  in  1  splitter enable (joyconf bit 7); level, synchronous to clk
db9_in  in  6  raw port {F2,F1,U,D,L,R}, 0 = pressed
joy_sel  out  1  splitter select: 0 = joystick A, 1 = joystick B (drives joy1fire3 pin)
joy1_out  out  6  registered joystick A word, 0 = pressed
joy2_out  out  6  registered joystick B word, 0 = pressed
sample_strobe  out  1  one-cycle pulse in the cycle after joy1_out or joy2_out was loaded
slot_b  out  1  current slot is B (debug/verification visibility; equals joy_sel)

Behaviour:
- Reset (async, rst=1): state PASS, cnt=0, joy_sel=0, joy1_out=6'h3F, joy2_out=6'h3F, sample_strobe=0.
- cnt width = $clog2(SLOT_CYCLES); counts 0..SLOT_CYCLES-1 and wraps to 0. Never exceeds SLOT_CYCLES-1.
- States: PASS, SLOT_A, SLOT_B.
- PASS (split_en=0):
  - joy_sel=0.
  - joy1_out <= db9_in every cycle (1-cycle latency).
  - joy2_out held at 6'h3F.
  - sample_strobe=0. cnt held at 0.
- PASS -> SLOT_A when split_en=1. In the same edge: cnt<=0, joy_sel<=0, joy2_out<=6'h3F.
- SLOT_A / SLOT_B:
  - cnt increments every cycle.
  - At cnt==SETTLE_CYCLES: sample db9_in into the current slot's output (A -> joy1_out, B -> joy2_out). The other output is held.
  - sample_strobe asserts the following cycle for exactly 1 cycle.
  - At cnt==SLOT_CYCLES-1: cnt<=0, state toggles A<->B, joy_sel toggles on the same edge.
  - joy_sel is registered and changes only on slot boundaries or on enable changes.
- Samples taken during cnt<SETTLE_CYCLES are never used, regardless of input glitches.
- split_en falling in any slot state: next edge goes to PASS, with joy_sel<=0, cnt<=0, joy2_out<=6'h3F. No pending sample or strobe survives; sample_strobe=0 from that edge.
- split_en rising while already in SLOT_A/SLOT_B: no effect.
- Simultaneous cnt==SLOT_CYCLES-1 and split_en=0: the disable wins (PASS, joy_sel=0).
- Outputs from a slot keep their last sampled value for the full period until the next sample of that same slot (no intermediate 3F).
- Async reset mid-slot: immediate return to reset values. After release, the block restarts from PASS.

Optional Feature:
JOYSPLIT_DEBOUNCE_EN:
- Defined: each slot keeps a previous-sample register (reset 6'h3F). A bit of joyN_out updates only when the current sample bit equals the previous sample bit of the same slot, i.e. a change needs two consecutive agreeing samples (~20 ms at defaults). The previous-sample register always loads the current sample. sample_strobe still pulses at every sample point. PASS mode is not debounced.
- Undefined: each sample is written directly, as described above.

Test Plan:
Use SLOT_CYCLES=16, SETTLE_CYCLES=4.
1. Reset with split_en=0; db9_in=6'h2E -> after 1 clk, joy1_out=6'h2E, joy2_out=6'h3F, joy_sel=0, no strobes.
2. split_en=1; db9_in=6'h3E while joy_sel=0 and 6'h1F while joy_sel=1 -> joy_sel toggles every 16 clk; joy1_out=6'h3E, joy2_out=6'h1F; sample_strobe pulses at cnt 5 of each slot (period 16).
3. Glitch db9_in=6'h00 during cnt 0..3 after each switch, correct value 6'h3D from cnt 4 -> outputs show only 6'h3D, never 6'h00.
4. Deassert split_en at cnt==15 of SLOT_B -> next edge joy_sel=0, joy2_out=6'h3F, joy1_out tracks db9_in with 1 clk latency, no strobe.
5. Assert rst at cnt==7 of SLOT_B -> joy_sel=0 and both outputs 6'h3F immediately (before the next clk edge).
6. With JOYSPLIT_DEBOUNCE_EN: slot A samples 3F, 3E, 3F, 3E, 3E -> joy1_out stays 3F through the 4th sample and becomes 3E at the 5th. Without the macro, joy1_out follows each sample.

Source files
------------

// File: rtl/joy_splitter_scheduler_if.sv
// joy_splitter_scheduler_if: joystick port, splitter control and decoded joystick words
interface joy_splitter_scheduler_if;
  logic       split_en;
  logic [5:0] db9_in;
  logic       joy_sel;
  logic [5:0] joy1_out;
  logic [5:0] joy2_out;
  logic       sample_strobe;
  logic       slot_b;
  modport master (output split_en, db9_in, input joy_sel, joy1_out, joy2_out, sample_strobe, slot_b);
  modport slave  (input split_en, db9_in, output joy_sel, joy1_out, joy2_out, sample_strobe, slot_b);
endinterface

// File: rtl/joy_splitter_scheduler.sv
// joy_splitter_scheduler: time-multiplexes one DB9 port between two joysticks via a splitter select.
// Optional JOYSPLIT_DEBOUNCE_EN: per-slot two-sample agreement before an output bit changes.
module joy_splitter_scheduler #(
  parameter int SLOT_CYCLES   = 140000,
  parameter int SETTLE_CYCLES = 64
) (
  input logic                      clk,
  input logic                      rst,
  joy_splitter_scheduler_if.slave  js_io
);
  localparam int CW = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0] SETTLE = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] LAST   = CW'(SLOT_CYCLES - 1);
  typedef enum logic [1:0] {PASS, SLOT_A, SLOT_B} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          sel_q, stb_q;
  logic [5:0]    j1_q, j2_q, j1_d, j2_d;
`ifdef JOYSPLIT_DEBOUNCE_EN
  logic [5:0]    pa_q, pb_q;
  // a bit moves only when this sample agrees with the previous one of the same slot
  always_comb begin
    j1_d = (~(js_io.db9_in ^ pa_q) & js_io.db9_in) | ((js_io.db9_in ^ pa_q) & j1_q);
    j2_d = (~(js_io.db9_in ^ pb_q) & js_io.db9_in) | ((js_io.db9_in ^ pb_q) & j2_q);
  end
`else
  always_comb begin
    j1_d = js_io.db9_in;
    j2_d = js_io.db9_in;
  end
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PASS;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      stb_q   <= 1'b0;
      j1_q    <= 6'h3F;
      j2_q    <= 6'h3F;
`ifdef JOYSPLIT_DEBOUNCE_EN
      pa_q    <= 6'h3F;
      pb_q    <= 6'h3F;
`endif
    end else begin
      stb_q <= 1'b0;
      if (state_q == PASS || !js_io.split_en) begin
        // disable wins over any slot boundary or pending sample
        state_q <= js_io.split_en ? SLOT_A : PASS;
        cnt_q   <= '0;
        sel_q   <= 1'b0;
        j1_q    <= js_io.db9_in;
        j2_q    <= 6'h3F;
      end else begin
        cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_q <= (state_q == SLOT_A) ? SLOT_B : SLOT_A;
          sel_q   <= ~sel_q;
        end
        if (cnt_q == SETTLE) begin
          stb_q <= 1'b1;
          if (state_q == SLOT_A) j1_q <= j1_d;
          else                   j2_q <= j2_d;
`ifdef JOYSPLIT_DEBOUNCE_EN
          if (state_q == SLOT_A) pa_q <= js_io.db9_in;
          else                   pb_q <= js_io.db9_in;
`endif
        end
      end
    end
  end
  assign js_io.joy_sel       = sel_q;
  assign js_io.slot_b        = sel_q;
  assign js_io.joy1_out      = j1_q;
  assign js_io.joy2_out      = j2_q;
  assign js_io.sample_strobe = stb_q;
endmodule

// File: tb/tb_joy_splitter_scheduler.sv
// tb_joy_splitter_scheduler: directed vectors plus slot-sequence checks at SLOT_CYCLES=16, SETTLE_CYCLES=4
module tb_joy_splitter_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  joy_splitter_scheduler_if js();
  joy_splitter_scheduler #(.SLOT_CYCLES(16), .SETTLE_CYCLES(4)) dut (.clk(clk), .rst(rst), .js_io(js));
  always #5 clk = ~clk;
  typedef struct {
    logic       en;
    logic [5:0] d;
    logic       sel;
    logic [5:0] j1;
    logic [5:0] j2;
    logic       stb;
  } vec_t;
  vec_t tbl[5];
  logic [3:0] bc;
  logic       bs, es;
  logic [5:0] e1, e2, p1, p2;
  logic [5:0] seq[5];
  task automatic chk(input string n, input logic [5:0] a, input logic [5:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_all(input string n, input logic sel, input logic [5:0] j1, input logic [5:0] j2, input logic stb);
    chk({n, ".sel"}, {5'b0, js.joy_sel}, {5'b0, sel});
    chk({n, ".slot_b"}, {5'b0, js.slot_b}, {5'b0, sel});
    chk({n, ".j1"}, js.joy1_out, j1);
    chk({n, ".j2"}, js.joy2_out, j2);
    chk({n, ".stb"}, {5'b0, js.sample_strobe}, {5'b0, stb});
  endtask
  task automatic upd(inout logic [5:0] e, inout logic [5:0] p, input logic [5:0] d);
    for (int i = 0; i < 6; i++) begin
`ifdef JOYSPLIT_DEBOUNCE_EN
      if (d[i] == p[i]) e[i] = d[i];
`else
      e[i] = d[i];
`endif
    end
    p = d;
  endtask
  task automatic model_reset();
    e1 = 6'h3F; e2 = 6'h3F; p1 = 6'h3F; p2 = 6'h3F;
  endtask
  task automatic slot_tick(input string n, input logic [5:0] d);
    js.db9_in = d;
    es = (bc == 4'd4);
    if (es) begin
      if (!bs) upd(e1, p1, d);
      else     upd(e2, p2, d);
    end
    if (bc == 4'd15) begin
      bc = 4'd0;
      bs = ~bs;
    end else bc = bc + 4'd1;
    tick();
    chk_all(n, bs, e1, e2, es);
  endtask
  task automatic enable_from_pass(input logic [5:0] d);
    js.split_en = 1'b1;
    js.db9_in   = d;
    tick();
    bc = 4'd0; bs = 1'b0; e1 = d; e2 = 6'h3F;
    chk_all("enable", 1'b0, e1, e2, 1'b0);
  endtask
  initial begin
    tbl[0] = '{1'b0, 6'h2E, 1'b0, 6'h2E, 6'h3F, 1'b0};
    tbl[1] = '{1'b0, 6'h15, 1'b0, 6'h15, 6'h3F, 1'b0};
    tbl[2] = '{1'b0, 6'h00, 1'b0, 6'h00, 6'h3F, 1'b0};
    tbl[3] = '{1'b0, 6'h3F, 1'b0, 6'h3F, 6'h3F, 1'b0};
    tbl[4] = '{1'b0, 6'h2A, 1'b0, 6'h2A, 6'h3F, 1'b0};
    seq[0] = 6'h3F; seq[1] = 6'h3E; seq[2] = 6'h3F; seq[3] = 6'h3E; seq[4] = 6'h3E;
    model_reset();
    bc = 4'd0; bs = 1'b0;
    js.split_en = 1'b0;
    js.db9_in   = 6'h2E;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 6'h3F, 6'h3F, 1'b0);
    rst = 1'b0;
    for (int v = 0; v < 5; v++) begin
      js.split_en = tbl[v].en;
      js.db9_in   = tbl[v].d;
      tick();
      chk_all($sformatf("vec%0d", v), tbl[v].sel, tbl[v].j1, tbl[v].j2, tbl[v].stb);
    end
    enable_from_pass(6'h3F);
    for (int k = 0; k < 64; k++) slot_tick("split", bs ? 6'h1F : 6'h3E);
    chk("split.j1_final", js.joy1_out, 6'h3E);
    chk("split.j2_final", js.joy2_out, 6'h1F);
    for (int k = 0; k < 64; k++) slot_tick("glitch", (bc < 4'd4) ? 6'h00 : 6'h3D);
    begin
      int g = 0;
      while (!(bs && bc == 4'd15) && g < 64) begin
        slot_tick("to_b15", 6'h3D);
        g++;
      end
      checks++;
      if (!(bs && bc == 4'd15)) begin
        errors++;
        $display("FAIL to_b15 bound got %0d want <64", g);
      end
    end
    js.split_en = 1'b0;
    js.db9_in   = 6'h2A;
    tick();
    chk_all("disable", 1'b0, 6'h2A, 6'h3F, 1'b0);
    js.db9_in = 6'h11;
    tick();
    chk_all("pass_track", 1'b0, 6'h11, 6'h3F, 1'b0);
    enable_from_pass(6'h3C);
    begin
      int g = 0;
      while (!(bs && bc == 4'd7) && g < 64) begin
        slot_tick("to_b7", bs ? 6'h1B : 6'h37);
        g++;
      end
      checks++;
      if (!(bs && bc == 4'd7)) begin
        errors++;
        $display("FAIL to_b7 bound got %0d want <64", g);
      end
    end
    rst = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 6'h3F, 6'h3F, 1'b0);
    tick();
    rst = 1'b0;
    model_reset();
    js.split_en = 1'b0;
    js.db9_in   = 6'h0F;
    tick();
    chk_all("post_rst_pass", 1'b0, 6'h0F, 6'h3F, 1'b0);
    enable_from_pass(6'h3F);
    for (int s = 0; s < 10; s++) begin
      for (int k = 0; k < 16; k++) slot_tick("deb", bs ? 6'h1F : seq[s / 2]);
`ifdef JOYSPLIT_DEBOUNCE_EN
      if (s == 6) chk("deb.after4", js.joy1_out, 6'h3F);
`else
      if (s == 6) chk("deb.after4", js.joy1_out, 6'h3E);
`endif
    end
    chk("deb.after5", js.joy1_out, 6'h3E);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
